// File: rtl/bcd_sub_scheduler_pkg.sv
// Shared definitions for the BCD subtractor scheduler.
//   - default channel count and operand width
//   - BCD digit weights used by the BCD-to-binary converter
//   - FSM state encoding
package bcd_sub_scheduler_pkg;

  localparam int unsigned DEF_N_REQ = 4;
  localparam int unsigned DEF_W     = 16;

  localparam int unsigned BCD_W1000 = 1000;
  localparam int unsigned BCD_W100  = 100;
  localparam int unsigned BCD_W10   = 10;
  localparam int unsigned BCD_DIGIT_MAX = 9;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CONV  = 3'd2,
    SUB   = 3'd3,
    WRITE = 3'd4
  } state_e;

endpackage

// File: rtl/bcd_sub_scheduler_bcd_to_bin.sv
// Combinational 4-digit packed BCD to binary converter.
// Ports:
//   i_bcd : W-bit packed BCD operand (digit k at bits [4k+3:4k])
//   o_bin : W-bit binary value d3*1000 + d2*100 + d1*10 + d0
//   o_err : set when any digit exceeds 9; such digits are taken as 9
module bcd_to_bin
  import bcd_sub_scheduler_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic [W-1:0] i_bcd,
  output logic [W-1:0] o_bin,
  output logic         o_err
);

  logic [3:0] w_dig [4];
  logic       w_err;

  // Extract and clamp digits, flagging any non-decimal nibble.
  always_comb begin
    w_err = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w_dig[k] = i_bcd[4*k +: 4];
      if (w_dig[k] > 4'(BCD_DIGIT_MAX)) begin
        w_dig[k] = 4'(BCD_DIGIT_MAX);
        w_err    = 1'b1;
      end
    end
  end

  assign o_bin = W'(w_dig[3]) * W'(BCD_W1000)
               + W'(w_dig[2]) * W'(BCD_W100)
               + W'(w_dig[1]) * W'(BCD_W10)
               + W'(w_dig[0]);
  assign o_err = w_err;

endmodule

// File: rtl/bcd_sub_scheduler.sv
// Round-robin scheduler sharing one BCD subtractor among N_REQ requesters.
// Each grant walks IDLE -> LOAD -> CONV -> SUB -> WRITE and produces the
// two's-complement binary difference a-b of the granted BCD operand pair.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   req_valid/req_a/b   : per-channel operand pairs (channel i at [i*W +: W])
//   req_rd              : one-hot pop strobe, high during LOAD
//   out_wr/out_full     : downstream write strobe / backpressure
//   out_data/src/err    : registered result, source channel, digit error
//   busy                : FSM not in IDLE
module bcd_sub_scheduler
  import bcd_sub_scheduler_pkg::*;
#(
  parameter  int unsigned N_REQ = DEF_N_REQ,
  parameter  int unsigned W     = DEF_W,
  localparam int unsigned SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_rd,
  output logic               out_wr,
  input  logic               out_full,
  output logic [W-1:0]       out_data,
  output logic [SRC_W-1:0]   out_src,
  output logic               out_err,
  output logic               busy
);

  state_e             r_state;
  logic [SRC_W-1:0]   r_rr_ptr;
  logic [SRC_W-1:0]   r_grant;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_a_bin;
  logic [W-1:0]       r_b_bin;
  logic               r_err;
  logic [N_REQ-1:0]   r_req_rd;
  logic [W-1:0]       r_out_data;
  logic [SRC_W-1:0]   r_out_src;
  logic               r_out_err;
  logic               r_busy;

  logic               w_any;
  logic               w_hi_found;
  logic [SRC_W-1:0]   w_grant_lo;
  logic [SRC_W-1:0]   w_grant_hi;
  logic [SRC_W-1:0]   w_grant;
  logic [N_REQ-1:0]   w_rd_onehot;
  logic [W-1:0]       w_sel_a;
  logic [W-1:0]       w_sel_b;
  logic [W-1:0]       w_a_bin;
  logic [W-1:0]       w_b_bin;
  logic               w_a_err;
  logic               w_b_err;
  logic [SRC_W-1:0]   w_rr_next;
  logic               w_out_wr;

  // Round-robin pick: lowest valid index >= rr_ptr, else lowest valid overall.
  // Scanning downward leaves the lowest matching index in each candidate.
  always_comb begin
    w_hi_found = 1'b0;
    w_grant_lo = '0;
    w_grant_hi = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_grant_lo = SRC_W'(i);
        if (i >= int'(r_rr_ptr)) begin
          w_grant_hi = SRC_W'(i);
          w_hi_found = 1'b1;
        end
      end
    end
    w_grant = w_hi_found ? w_grant_hi : w_grant_lo;
  end

  assign w_any = |req_valid;

  // Pop strobe for the new grant and operand mux for the held grant.
  always_comb begin
    w_rd_onehot = '0;
    w_sel_a     = '0;
    w_sel_b     = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (w_grant == SRC_W'(i)) begin
        w_rd_onehot[i] = 1'b1;
      end
      if (r_grant == SRC_W'(i)) begin
        w_sel_a = req_a[i*W +: W];
        w_sel_b = req_b[i*W +: W];
      end
    end
  end

  assign w_rr_next = (r_grant == SRC_W'(N_REQ - 1)) ? '0 : r_grant + SRC_W'(1);

  bcd_to_bin #(.W(W)) u_conv_a (
    .i_bcd (r_a),
    .o_bin (w_a_bin),
    .o_err (w_a_err)
  );

  bcd_to_bin #(.W(W)) u_conv_b (
    .i_bcd (r_b),
    .o_bin (w_b_bin),
    .o_err (w_b_err)
  );

  // The write strobe must react to out_full in the same cycle, so it is
  // decoded from the registered state rather than registered itself.
  assign w_out_wr = (r_state == WRITE) && !out_full;

  // Scheduler FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_grant    <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_a_bin    <= '0;
      r_b_bin    <= '0;
      r_err      <= 1'b0;
      r_req_rd   <= '0;
      r_out_data <= '0;
      r_out_src  <= '0;
      r_out_err  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_req_rd <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant  <= w_grant;
            r_req_rd <= w_rd_onehot;
            r_busy   <= 1'b1;
            r_state  <= LOAD;
          end
        end
        LOAD: begin
          r_a     <= w_sel_a;
          r_b     <= w_sel_b;
          r_state <= CONV;
        end
        CONV: begin
          r_a_bin <= w_a_bin;
          r_b_bin <= w_b_bin;
          r_err   <= w_a_err | w_b_err;
          r_state <= SUB;
        end
        SUB: begin
          r_out_data <= r_a_bin - r_b_bin;
          r_out_src  <= r_grant;
          r_out_err  <= r_err;
          r_state    <= WRITE;
        end
        WRITE: begin
          if (!out_full) begin
            r_rr_ptr <= w_rr_next;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req_rd   = r_req_rd;
  assign out_wr   = w_out_wr;
  assign out_data = r_out_data;
  assign out_src  = r_out_src;
  assign out_err  = r_out_err;
  assign busy     = r_busy;

endmodule

// File: tb/tb_bcd_sub_scheduler.sv
// Directed bench for bcd_sub_scheduler (N_REQ=4, W=16).
module tb_bcd_sub_scheduler;

  localparam int unsigned N = 4;
  localparam int unsigned W = 16;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_rd;
  logic           out_wr;
  logic           out_full;
  logic [W-1:0]   out_data;
  logic [1:0]     out_src;
  logic           out_err;
  logic           busy;

  int n_cmp = 0;
  int n_err = 0;

  bcd_sub_scheduler #(.N_REQ(N), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_rd    (req_rd),
    .out_wr    (out_wr),
    .out_full  (out_full),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_err   (out_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic [15:0] a, input logic [15:0] b);
    req_a[ch*W +: W] = a;
    req_b[ch*W +: W] = b;
  endtask

  // One request with no backpressure: pop in cycle 1, write in cycle 4.
  task automatic single(input int ch, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_d, input logic exp_e);
    logic [3:0] oh;
    oh = 4'b0001 << ch;
    set_ch(ch, a, b);
    req_valid = oh;
    tick();
    chk("c1_req_rd", 32'(req_rd), 32'(oh));
    chk("c1_busy", 32'(busy), 32'd1);
    req_valid = '0;
    tick();
    chk("c2_rd_wr", 32'({req_rd, out_wr}), 32'd0);
    tick();
    chk("c3_wr", 32'(out_wr), 32'd0);
    tick();
    chk("c4_wr", 32'(out_wr), 32'd1);
    chk("c4_data", 32'(out_data), 32'(exp_d));
    chk("c4_src", 32'(out_src), 32'(ch));
    chk("c4_err", 32'(out_err), 32'(exp_e));
    tick();
    chk("c5_wr_busy", 32'({out_wr, busy}), 32'd0);
  endtask

  logic [1:0]  exp_src [4];
  logic [15:0] exp_dat [4];
  int          n_rd;
  int          n_wr;

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    out_full  = 1'b0;
    tick();
    tick();
    chk("rst_rd", 32'(req_rd), 32'd0);
    chk("rst_wr", 32'(out_wr), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_src_err_busy", 32'({out_src, out_err, busy}), 32'd0);
    reset = 1'b0;
    tick();

    // Basic subtraction on ch0 and a negative result on ch2.
    single(0, 16'h1234, 16'h0034, 16'h04B0, 1'b0);
    single(2, 16'h0010, 16'h0025, 16'hFFF1, 1'b0);

    // ch1 with the downstream full for three WRITE cycles.
    set_ch(1, 16'h0500, 16'h0123);
    req_valid = 4'b0010;
    out_full  = 1'b1;
    tick();
    chk("bp_req_rd", 32'(req_rd), 32'h2);
    req_valid = '0;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_wr_held", 32'(out_wr), 32'd0);
      chk("bp_data_held", 32'(out_data), 32'h0179);
    end
    out_full = 1'b0;
    #1;
    chk("bp_wr_release", 32'(out_wr), 32'd1);
    chk("bp_data", 32'(out_data), 32'h0179);
    chk("bp_src", 32'(out_src), 32'd1);
    tick();
    chk("bp_wr_once", 32'(out_wr), 32'd0);
    chk("bp_data_kept", 32'(out_data), 32'h0179);

    // Non-decimal digit clamped to 9, then the equivalent legal operand.
    single(3, 16'h00A0, 16'h0000, 16'h005A, 1'b1);
    single(3, 16'h0090, 16'h0000, 16'h005A, 1'b0);

    // All channels continuously valid: grant order 0,1,2,3.
    for (int i = 0; i < 4; i++) begin
      set_ch(i, 16'h1111 * 16'(i + 1), 16'h0111);
      exp_src[i] = 2'(i);
    end
    exp_dat[0] = 16'h03E8;
    exp_dat[1] = 16'h083F;
    exp_dat[2] = 16'h0C96;
    exp_dat[3] = 16'h10ED;
    n_rd = 0;
    n_wr = 0;
    req_valid = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (req_rd != '0) begin
        chk("rr_rd_onehot", 32'($onehot(req_rd)), 32'd1);
        n_rd++;
      end
      if (out_wr && n_wr < 4) begin
        chk("rr_src", 32'(out_src), 32'(exp_src[n_wr]));
        chk("rr_data", 32'(out_data), 32'(exp_dat[n_wr]));
        n_wr++;
      end
    end
    req_valid = '0;
    chk("rr_rd_count", 32'(n_rd), 32'd4);
    chk("rr_wr_count", 32'(n_wr), 32'd4);
    tick();

    // out_full falls while a new request rises: write first, then arbitrate.
    set_ch(0, 16'h0100, 16'h0001);
    req_valid = 4'b0001;
    out_full  = 1'b1;
    tick();
    chk("ovl_rd0", 32'(req_rd), 32'h1);
    req_valid = '0;
    tick();
    tick();
    tick();
    chk("ovl_wr_full", 32'(out_wr), 32'd0);
    tick();
    set_ch(2, 16'h0003, 16'h0005);
    out_full  = 1'b0;
    req_valid = 4'b0100;
    #1;
    chk("ovl_wr", 32'(out_wr), 32'd1);
    chk("ovl_data", 32'(out_data), 32'h0063);
    chk("ovl_rd_none", 32'(req_rd), 32'd0);
    tick();
    chk("ovl_idle", 32'({req_rd, out_wr, busy}), 32'd0);
    tick();
    chk("ovl_rd2", 32'(req_rd), 32'h4);
    req_valid = '0;
    tick();
    tick();
    tick();
    chk("ovl_wr2", 32'(out_wr), 32'd1);
    chk("ovl_data2", 32'(out_data), 32'hFFFE);
    chk("ovl_src2", 32'(out_src), 32'd2);
    tick();

    // Leave rr_ptr at 2, then reset during SUB of a ch3 request.
    single(1, 16'h0002, 16'h0001, 16'h0001, 1'b0);
    set_ch(3, 16'h0099, 16'h0001);
    req_valid = 4'b1000;
    tick();
    chk("rst_mid_rd3", 32'(req_rd), 32'h8);
    req_valid = '0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rst_mid_outs", 32'({req_rd, out_wr, out_src, out_err, busy}), 32'd0);
    chk("rst_mid_data", 32'(out_data), 32'd0);
    tick();
    tick();
    chk("rst_mid_no_wr", 32'({req_rd, out_wr}), 32'd0);
    reset = 1'b0;
    set_ch(1, 16'h0050, 16'h0020);
    req_valid = 4'b1010;
    tick();
    chk("rst_grant_ch1", 32'(req_rd), 32'h2);
    req_valid = '0;
    tick();
    tick();
    tick();
    chk("rst_post_wr", 32'(out_wr), 32'd1);
    chk("rst_post_data", 32'(out_data), 32'h001E);
    chk("rst_post_src", 32'(out_src), 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
